// File: rtl/infc_tx_source.sv
// Stream producer endpoint: host FIFO feeding a registered data/ready output stage.
// Optional macro INFC_TX_STATS_EN adds a wrapping transfer counter with synchronous clear.
module infc_tx_source #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
`ifdef INFC_TX_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_full,
    input  logic                       tx_pause,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DATA_W-1:0]          infc_data,
    output logic                       infc_ready,
`ifdef INFC_TX_STATS_EN
    output logic [CNT_W-1:0]           tx_count,
    input  logic                       tx_count_clr,
`endif
    input  logic                       infc_enable
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_ZERO    = (AW+1)'(0);

    typedef enum logic [0:0] {
        ST_EMPTY   = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;
    logic [DATA_W-1:0]   r_data;
    logic                w_push;
    logic                w_load;
    logic                w_xfer;
    logic                w_fifo_ne;

    assign wr_full    = (r_count == C_FULL);
    assign w_fifo_ne  = (r_count != C_ZERO);
    assign w_push     = wr_valid & ~wr_full;
    assign infc_ready = (r_state == ST_PRESENT);
    assign w_xfer     = infc_ready & infc_enable;
    assign infc_data  = r_data;
    assign level      = r_count + {{AW{1'b0}}, infc_ready};

    // Output-stage next state and FIFO pop (load) decision
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_fifo_ne && !tx_pause) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_PRESENT: begin
                if (w_xfer && w_fifo_ne && !tx_pause) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            default: begin
                w_load      = 1'b0;
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Output-stage state and presented word
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_EMPTY;
            r_data  <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_data <= r_mem[r_rptr];
            end
        end
    end

    // FIFO storage; contents are don't-care until a pointer covers them
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; a pushed word is only visible to a load one cycle later
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= C_ZERO;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_load) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INFC_TX_STATS_EN
    localparam logic [CNT_W-1:0] C_TX_ONE = CNT_W'(1);
    logic [CNT_W-1:0] r_tx_count;

    assign tx_count = r_tx_count;

    // Transfer counter; clear takes priority over a same-edge transfer
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_tx_count <= {CNT_W{1'b0}};
        end else if (tx_count_clr) begin
            r_tx_count <= {CNT_W{1'b0}};
        end else if (w_xfer) begin
            r_tx_count <= r_tx_count + C_TX_ONE;
        end else begin
            r_tx_count <= r_tx_count;
        end
    end
`endif

endmodule

// File: tb/tb_infc_tx_source.sv
// Directed bench for infc_tx_source: reset, single word, streaming, full, pause, async reset, stats.
module tb_infc_tx_source;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_full;
    logic        tx_pause = 1'b0;
    logic [3:0]  level;
    logic [31:0] infc_data;
    logic        infc_ready;
    logic        infc_enable = 1'b0;
`ifdef INFC_TX_STATS_EN
    logic [3:0]  tx_count;
    logic        tx_count_clr = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    infc_tx_source #(
        .DATA_W(32),
        .DEPTH (8)
`ifdef INFC_TX_STATS_EN
        ,
        .CNT_W (4)
`endif
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .tx_pause    (tx_pause),
        .level       (level),
        .infc_data   (infc_data),
        .infc_ready  (infc_ready),
`ifdef INFC_TX_STATS_EN
        .tx_count    (tx_count),
        .tx_count_clr(tx_count_clr),
`endif
        .infc_enable (infc_enable)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset then idle
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ready", 64'(infc_ready), 64'd0);
        chk("rst_data",  64'(infc_data),  64'd0);
        chk("rst_level", 64'(level),      64'd0);
        chk("rst_full",  64'(wr_full),    64'd0);
        sys_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_ready", 64'(infc_ready), 64'd0);
        end

        // Single word with stalled consumer
        wr_valid = 1'b1;
        wr_data  = 32'hA5A5_0001;
        step();
        wr_valid = 1'b0;
        wr_data  = 32'hFFFF_FFFF;
        chk("one_push_ready", 64'(infc_ready), 64'd0);
        chk("one_push_level", 64'(level),      64'd1);
        step();
        chk("one_load_ready", 64'(infc_ready), 64'd1);
        chk("one_load_data",  64'(infc_data),  64'hA5A5_0001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("one_hold_ready", 64'(infc_ready), 64'd1);
            chk("one_hold_data",  64'(infc_data),  64'hA5A5_0001);
            chk("one_hold_level", 64'(level),      64'd1);
        end
        infc_enable = 1'b1;
        step();
        infc_enable = 1'b0;
        chk("one_xfer_ready", 64'(infc_ready), 64'd0);
        chk("one_xfer_level", 64'(level),      64'd0);

        // Streaming 1..8 with consumer always accepting
        infc_enable = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            wr_valid = (s <= 8);
            wr_data  = 32'(s);
            step();
            if (s == 1 || s == 10) begin
                chk("strm_ready_lo", 64'(infc_ready), 64'd0);
            end else begin
                chk("strm_ready_hi", 64'(infc_ready), 64'd1);
                chk("strm_data",     64'(infc_data),  64'(s - 1));
            end
        end
        wr_valid = 1'b0;
        infc_enable = 1'b0;
        chk("strm_level_end", 64'(level), 64'd0);

        // Full boundary: 10 pushes, consumer stalled
        for (int s = 1; s <= 10; s++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h100 + 32'(s);
            step();
            if (s == 8) chk("full_at8", 64'(wr_full), 64'd0);
            if (s == 9) chk("full_at9", 64'(wr_full), 64'd1);
            if (s == 9) chk("level_at9", 64'(level), 64'd9);
        end
        chk("full_at10",  64'(wr_full), 64'd1);
        chk("level_at10", 64'(level),   64'd9);
        wr_data     = 32'hDEAD;
        infc_enable = 1'b1;
        step();
        wr_valid    = 1'b0;
        infc_enable = 1'b0;
        chk("full_pop_level", 64'(level),     64'd8);
        chk("full_pop_full",  64'(wr_full),   64'd0);
        chk("full_pop_data",  64'(infc_data), 64'h102);
        infc_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 7) chk("drain_data", 64'(infc_data), 64'h103 + 64'(i));
            else       chk("drain_ready", 64'(infc_ready), 64'd0);
        end
        infc_enable = 1'b0;

        // Pause: presented word still leaves, then nothing new launched
        for (int s = 1; s <= 4; s++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h200 + 32'(s);
            step();
        end
        wr_valid = 1'b0;
        chk("pause_pre_data",  64'(infc_data), 64'h201);
        chk("pause_pre_level", 64'(level),     64'd4);
        tx_pause    = 1'b1;
        infc_enable = 1'b1;
        step();
        chk("pause_xfer_ready", 64'(infc_ready), 64'd0);
        chk("pause_xfer_level", 64'(level),      64'd3);
        step();
        chk("pause_hold_ready", 64'(infc_ready), 64'd0);
        chk("pause_hold_level", 64'(level),      64'd3);
        tx_pause = 1'b0;
        step();
        infc_enable = 1'b0;
        chk("unpause_ready", 64'(infc_ready), 64'd1);
        chk("unpause_data",  64'(infc_data),  64'h202);

        // Mid-stream asynchronous reset with words queued
        for (int s = 5; s <= 6; s++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h200 + 32'(s);
            step();
        end
        wr_valid = 1'b0;
        chk("mid_pre_level", 64'(level), 64'd5);
        #2;
        sys_rst = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(infc_ready), 64'd0);
        chk("mid_rst_level", 64'(level),      64'd0);
        chk("mid_rst_data",  64'(infc_data),  64'd0);
        #3;
        sys_rst = 1'b1;
        step();
        step();
        chk("mid_post_ready", 64'(infc_ready), 64'd0);
        chk("mid_post_level", 64'(level),      64'd0);

`ifdef INFC_TX_STATS_EN
        // Stats: 17 transfers wrap a 4-bit counter to 1, then clear beats increment
        chk("cnt_reset", 64'(tx_count), 64'd0);
        infc_enable = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            wr_valid = (s <= 17);
            wr_data  = 32'h300 + 32'(s);
            step();
        end
        wr_valid    = 1'b0;
        infc_enable = 1'b0;
        chk("cnt_17", 64'(tx_count), 64'd1);
        wr_valid = 1'b1;
        wr_data  = 32'h400;
        step();
        wr_valid = 1'b0;
        step();
        chk("cnt_clr_pre_ready", 64'(infc_ready), 64'd1);
        infc_enable  = 1'b1;
        tx_count_clr = 1'b1;
        step();
        infc_enable  = 1'b0;
        tx_count_clr = 1'b0;
        chk("cnt_clr", 64'(tx_count), 64'd0);
        chk("cnt_clr_ready", 64'(infc_ready), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
